// File: rtl/cmp_pkg.sv
// Shared types and the round-robin pick helper for the compare arbiter.
package cmp_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic equal;
        logic greater;
        logic lesser;
    } cmp_res_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [PTR_W-1:0]   ptr,
                                         input int unsigned        nreq);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                j = 32'(ptr) + k;
                if (j >= nreq) j = j - nreq;
                if (!r.found && valid[j[PTR_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[PTR_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational unsigned W-bit magnitude comparator.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output cmp_res_t     res_c
);

    // Exactly one flag set for any operand pair.
    always_comb begin
        res_c         = '0;
        res_c.equal   = (a == b);
        res_c.greater = (a > b);
        res_c.lesser  = (a < b);
    end

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one registered comparator between NREQ clients.
module cmp_rr_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ack,
    output logic              rsp_equal,
    output logic              rsp_greater,
    output logic              rsp_lesser,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    cmp_res_t        res_q, res_d;
    cmp_res_t        core_res;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    rr_pick_t        pick;
    int unsigned     sel;

    cmp_core #(.W(W)) u_core (
        .a     (a_q),
        .b     (b_q),
        .res_c (core_res)
    );

    // State, pointer, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Arbitration in IDLE, result capture in CMP, hold until owner acks in RESP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        pick        = rr_pick(MAX_REQ'(req_valid), PTR_W'(ptr_q), NREQ);
        sel         = 32'(pick.idx);

        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    req_ready = NREQ'(1) << pick.idx;
                    a_d       = req_a[sel*W +: W];
                    b_d       = req_b[sel*W +: W];
                    id_d      = IDW'(pick.idx);
                    if (pick.idx == PTR_W'(NREQ - 1)) ptr_d = '0;
                    else                              ptr_d = IDW'(pick.idx + PTR_W'(1));
                    state_d   = CMP;
                end
            end
            CMP: begin
                res_d       = core_res;
                rsp_valid_d = NREQ'(1) << id_q;
                state_d     = RESP;
            end
            RESP: begin
                // rsp_valid_q is one-hot on the owner, so this picks out only its ack.
                if (|(rsp_ack & rsp_valid_q)) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_equal   = res_q.equal;
    assign rsp_greater = res_q.greater;
    assign rsp_lesser  = res_q.lesser;
    assign rsp_id      = id_q;
    assign busy        = (state_q != IDLE);

endmodule
